sys_bus_nm: RTL and testbench

SYS_BUS_NM -- requirements
Module: sys_bus_nm

---
 rtl/sys_bus_nm.sv | 158 +++++++++++++++
 tb/tb_sys_bus_nm.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sys_bus_nm.sv
// Multi-master / multi-slave system bus: fixed or round-robin arbitration with lock,
// addr[31:28] slave decode, one-cycle registered read return and a decode-error pulse.
module sys_bus_nm #(
    parameter int                 N_MST    = 4,
    parameter int                 N_SLV    = 4,
    parameter int                 DW       = 32,
    parameter int                 ARB_MODE = 0,
    parameter logic [4*N_SLV-1:0] SLV_BASE = {4'h8, 4'h4, 4'h2, 4'h0}
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [N_MST-1:0]      i_req,
    input  logic [N_MST-1:0]      i_lock,
    output logic [N_MST-1:0]      o_gnt,
    input  logic [N_MST*32-1:0]   i_addr,
    input  logic [N_MST-1:0]      i_write,
    input  logic [N_MST-1:0]      i_read,
    input  logic [N_MST*4-1:0]    i_size,
    input  logic [N_MST*DW-1:0]   i_din,
    output logic [N_MST*DW-1:0]   o_dout,
    output logic [N_MST-1:0]      o_rvalid,
    output logic [N_SLV*32-1:0]   o_s_addr,
    output logic [N_SLV-1:0]      o_s_write,
    output logic [N_SLV-1:0]      o_s_read,
    output logic [N_SLV*4-1:0]    o_s_size,
    output logic [N_SLV*DW-1:0]   o_s_din,
    input  logic [N_SLV*DW-1:0]   i_s_dout,
    output logic                  o_dec_err
);

    localparam int MW = $clog2(N_MST);
    localparam int SW = (N_SLV > 1) ? $clog2(N_SLV) : 1;

    logic [MW-1:0]  r_rr_ptr;
    logic [MW-1:0]  r_lk_own;
    logic           r_lk_vld;
    logic           r_rv;
    logic [MW-1:0]  r_rv_own;
    logic [SW-1:0]  r_rv_tgt;
    logic           r_rv_miss;
    logic           r_dec_err;

    logic           w_gnt_any;
    logic [MW-1:0]  w_gnt_idx;
    logic [MW-1:0]  w_ptr_nxt;
    logic [31:0]    w_m_addr;
    logic           w_m_wr;
    logic           w_m_rd;
    logic [3:0]     w_m_size;
    logic [DW-1:0]  w_m_din;
    logic           w_m_lock;
    logic           w_hit;
    logic [SW-1:0]  w_tgt;

    // A live lock overrides arbitration; otherwise the lowest index (fixed) or the
    // first requester at/after the pointer (round-robin) wins.
    always_comb begin
        w_gnt_any = 1'b0;
        w_gnt_idx = '0;
        if (r_lk_vld && i_lock[r_lk_own]) begin
            w_gnt_any = 1'b1;
            w_gnt_idx = r_lk_own;
        end else if (ARB_MODE == 0) begin
            for (int i = N_MST-1; i >= 0; i--) begin
                if (i_req[i]) begin
                    w_gnt_any = 1'b1;
                    w_gnt_idx = MW'(i);
                end
            end
        end else begin
            for (int k = N_MST-1; k >= 0; k--) begin
                if (i_req[(int'(r_rr_ptr) + k) % N_MST]) begin
                    w_gnt_any = 1'b1;
                    w_gnt_idx = MW'((int'(r_rr_ptr) + k) % N_MST);
                end
            end
        end
    end

    always_comb begin
        o_gnt = '0;
        o_gnt[w_gnt_idx] = w_gnt_any;
    end

    assign w_m_addr  = i_addr[int'(w_gnt_idx)*32 +: 32];
    assign w_m_size  = i_size[int'(w_gnt_idx)*4 +: 4];
    assign w_m_din   = i_din[int'(w_gnt_idx)*DW +: DW];
    assign w_m_wr    = w_gnt_any & i_write[w_gnt_idx];
    assign w_m_rd    = w_gnt_any & i_read[w_gnt_idx];
    assign w_m_lock  = w_gnt_any & i_lock[w_gnt_idx];
    assign w_ptr_nxt = (w_gnt_idx == MW'(N_MST-1)) ? '0 : w_gnt_idx + 1'b1;

    // Reverse scan so the lowest matching slave wins when bases overlap.
    always_comb begin
        w_hit = 1'b0;
        w_tgt = '0;
        for (int s = N_SLV-1; s >= 0; s--) begin
            if (SLV_BASE[4*s +: 4] == w_m_addr[31:28]) begin
                w_hit = 1'b1;
                w_tgt = SW'(s);
            end
        end
    end

    always_comb begin
        o_s_addr  = '0;
        o_s_write = '0;
        o_s_read  = '0;
        o_s_size  = '0;
        o_s_din   = '0;
        if (w_gnt_any && w_hit) begin
            o_s_addr[int'(w_tgt)*32 +: 32] = w_m_addr;
            o_s_write[w_tgt]               = w_m_wr;
            o_s_read[w_tgt]                = w_m_rd;
            o_s_size[int'(w_tgt)*4 +: 4]   = w_m_size;
            o_s_din[int'(w_tgt)*DW +: DW]  = w_m_din;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rr_ptr  <= '0;
            r_lk_vld  <= 1'b0;
            r_lk_own  <= '0;
            r_rv      <= 1'b0;
            r_rv_own  <= '0;
            r_rv_tgt  <= '0;
            r_rv_miss <= 1'b0;
            r_dec_err <= 1'b0;
        end else begin
            r_lk_vld <= w_m_lock;
            r_lk_own <= w_gnt_idx;
            // Locked beats leave the pointer alone so the owner's tenure is not counted as a turn.
            if (w_gnt_any && !w_m_lock) begin
                r_rr_ptr <= w_ptr_nxt;
            end
            r_rv      <= w_m_rd;
            r_rv_own  <= w_gnt_idx;
            r_rv_tgt  <= w_tgt;
            r_rv_miss <= ~w_hit;
            r_dec_err <= w_gnt_any & ~w_hit & (w_m_rd | w_m_wr);
        end
    end

    assign o_dec_err = r_dec_err;

    always_comb begin
        o_rvalid = '0;
        o_dout   = '0;
        if (r_rv) begin
            o_rvalid[r_rv_own] = 1'b1;
            if (!r_rv_miss) begin
                o_dout[int'(r_rv_own)*DW +: DW] = i_s_dout[int'(r_rv_tgt)*DW +: DW];
            end
        end
    end

endmodule

// File: tb/tb_sys_bus_nm.sv
// Bench for sys_bus_nm: a fixed-priority and a round-robin instance share the master
// and slave inputs; directed scenarios plus a randomized run against a behavioural model.
module tb_sys_bus_nm;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   req, lock, wr, rd;
    logic [127:0] addr, din, s_dout;
    logic [15:0]  size;

    logic [3:0]   gnt     [2];
    logic [127:0] dout    [2];
    logic [3:0]   rvalid  [2];
    logic [127:0] s_addr  [2];
    logic [3:0]   s_write [2];
    logic [3:0]   s_read  [2];
    logic [15:0]  s_size  [2];
    logic [127:0] s_din   [2];
    logic         dec_err [2];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sys_bus_nm #(.ARB_MODE(0)) dut_fix (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_lock(lock), .o_gnt(gnt[0]),
        .i_addr(addr), .i_write(wr), .i_read(rd), .i_size(size), .i_din(din),
        .o_dout(dout[0]), .o_rvalid(rvalid[0]),
        .o_s_addr(s_addr[0]), .o_s_write(s_write[0]), .o_s_read(s_read[0]),
        .o_s_size(s_size[0]), .o_s_din(s_din[0]), .i_s_dout(s_dout), .o_dec_err(dec_err[0])
    );

    sys_bus_nm #(.ARB_MODE(1)) dut_rr (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_lock(lock), .o_gnt(gnt[1]),
        .i_addr(addr), .i_write(wr), .i_read(rd), .i_size(size), .i_din(din),
        .o_dout(dout[1]), .o_rvalid(rvalid[1]),
        .o_s_addr(s_addr[1]), .o_s_write(s_write[1]), .o_s_read(s_read[1]),
        .o_s_size(s_size[1]), .o_s_din(s_din[1]), .i_s_dout(s_dout), .o_dec_err(dec_err[1])
    );

    task automatic clear_in();
        req = '0; lock = '0; wr = '0; rd = '0; addr = '0; din = '0; size = '0;
    endtask

    task automatic cmd(input int m, input logic r, input logic w, input logic [31:0] a);
        req[m] = 1'b1;
        rd[m]  = r;
        wr[m]  = w;
        addr[m*32 +: 32] = a;
        din[m*32 +: 32]  = 32'hD000_0000 + m;
        size[m*4 +: 4]   = 4'h2;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_in();
        s_dout = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_in();
        s_dout = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
        cmd(1, 1'b1, 1'b0, 32'h2000_0000);
        cmd(3, 1'b0, 1'b0, 32'h0);
        #1;
        for (int m = 0; m < 2; m++) begin
            n_cmp++;
            if (gnt[m] !== 4'b0010) begin
                n_bad++; $display("FAIL reset_gnt m%0d got %b exp 0010", m, gnt[m]);
            end
            n_cmp++;
            if (s_read[m] !== 4'b0010) begin
                n_bad++; $display("FAIL reset_s_read m%0d got %b exp 0010", m, s_read[m]);
            end
        end
        @(negedge clk);
        #1;
        for (int m = 0; m < 2; m++) begin
            n_cmp++;
            if (rvalid[m] !== 4'b0 || dout[m] !== '0 || dec_err[m] !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_regs m%0d got rv=%b dout=%h de=%b exp 0/0/0", m, rvalid[m], dout[m], dec_err[m]);
            end
        end
        clear_in();
        req = 4'b1100;
        #1;
        n_cmp++;
        if (gnt[1] !== 4'b0100) begin
            n_bad++; $display("FAIL reset_rr_ptr0 got %b exp 0100", gnt[1]);
        end
        @(negedge clk);
        clear_in();
        rst_n = 1'b1;
    endtask

    task automatic test_fixed_read();
        apply_reset();
        @(negedge clk);
        req = 4'b1010;
        cmd(1, 1'b1, 1'b0, 32'h4000_0010);
        cmd(3, 1'b0, 1'b1, 32'h0000_0000);
        s_dout = {32'h0, 32'h1234_5678, 32'h0BAD_0BAD, 32'h0};
        #1;
        n_cmp++;
        if (gnt[0] !== 4'b0010) begin
            n_bad++; $display("FAIL fix_gnt got %b exp 0010", gnt[0]);
        end
        n_cmp++;
        if (s_read[0] !== 4'b0100 || s_write[0] !== 4'b0) begin
            n_bad++; $display("FAIL fix_strobe got rd=%b wr=%b exp 0100/0000", s_read[0], s_write[0]);
        end
        n_cmp++;
        if (s_addr[0] !== {32'h0, 32'h4000_0010, 64'h0} || s_din[0] !== {32'h0, 32'hD000_0001, 64'h0}) begin
            n_bad++; $display("FAIL fix_s_cmd got addr=%h din=%h", s_addr[0], s_din[0]);
        end
        @(negedge clk);
        clear_in();
        cmd(1, 1'b1, 1'b0, 32'h2000_0010);
        #1;
        n_cmp++;
        if (rvalid[0] !== 4'b0010 || dout[0] !== {64'h0, 32'h1234_5678, 32'h0}) begin
            n_bad++; $display("FAIL fix_ret got rv=%b dout=%h exp 0010 / slave2 data", rvalid[0], dout[0]);
        end
        n_cmp++;
        if (s_read[0] !== 4'b0010) begin
            n_bad++; $display("FAIL fix_slave1 got %b exp 0010", s_read[0]);
        end
        @(negedge clk);
        clear_in();
        #1;
        n_cmp++;
        if (rvalid[0] !== 4'b0010 || dout[0] !== {64'h0, 32'h0BAD_0BAD, 32'h0}) begin
            n_bad++; $display("FAIL fix_ret_s1 got rv=%b dout=%h", rvalid[0], dout[0]);
        end
    endtask

    task automatic test_rr();
        logic [3:0] exp_g [5];
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            req = 4'hF;
            #1;
            n_cmp++;
            if (gnt[1] !== exp_g[i]) begin
                n_bad++; $display("FAIL rr_seq cyc%0d got %b exp %b", i, gnt[1], exp_g[i]);
            end
            n_cmp++;
            if (gnt[0] !== 4'b0001) begin
                n_bad++; $display("FAIL fix_seq cyc%0d got %b exp 0001", i, gnt[0]);
            end
        end
        @(negedge clk);
        clear_in();
    endtask

    task automatic test_lock();
        logic [3:0] t_req [5];
        logic [3:0] t_lck [5];
        logic [3:0] t_fix [5];
        logic [3:0] t_rr  [5];
        t_req = '{4'b0100, 4'b0101, 4'b0101, 4'b0001, 4'b0101};
        t_lck = '{4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000};
        t_fix = '{4'b0100, 4'b0100, 4'b0100, 4'b0001, 4'b0001};
        t_rr  = '{4'b0100, 4'b0100, 4'b0100, 4'b0001, 4'b0100};
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            req  = t_req[i];
            lock = t_lck[i];
            #1;
            n_cmp++;
            if (gnt[0] !== t_fix[i] || gnt[1] !== t_rr[i]) begin
                n_bad++;
                $display("FAIL lock cyc%0d got fix=%b rr=%b exp %b/%b", i, gnt[0], gnt[1], t_fix[i], t_rr[i]);
            end
        end
        @(negedge clk);
        clear_in();
    endtask

    task automatic test_dec_err();
        apply_reset();
        @(negedge clk);
        cmd(0, 1'b1, 1'b0, 32'hF000_0000);
        #1;
        n_cmp++;
        if (gnt[0] !== 4'b0001 || s_read[0] !== 4'b0 || s_addr[0] !== '0 || dec_err[0] !== 1'b0) begin
            n_bad++; $display("FAIL miss_cmd got gnt=%b srd=%b saddr=%h de=%b", gnt[0], s_read[0], s_addr[0], dec_err[0]);
        end
        @(negedge clk);
        clear_in();
        s_dout = {4{32'hCAFE_F00D}};
        cmd(2, 1'b0, 1'b1, 32'hB000_0000);
        #1;
        n_cmp++;
        if (dec_err[0] !== 1'b1 || rvalid[0] !== 4'b0001 || dout[0] !== '0) begin
            n_bad++; $display("FAIL miss_ret got de=%b rv=%b dout=%h exp 1/0001/0", dec_err[0], rvalid[0], dout[0]);
        end
        @(negedge clk);
        clear_in();
        #1;
        n_cmp++;
        if (dec_err[0] !== 1'b1 || rvalid[0] !== 4'b0) begin
            n_bad++; $display("FAIL miss_wr got de=%b rv=%b exp 1/0000", dec_err[0], rvalid[0]);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (dec_err[0] !== 1'b0 || dec_err[1] !== 1'b0) begin
            n_bad++; $display("FAIL miss_pulse got %b%b exp 00", dec_err[0], dec_err[1]);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        @(negedge clk);
        cmd(0, 1'b1, 1'b0, 32'h0000_0040);
        s_dout = {32'h0, 32'h0, 32'h0, 32'hAAAA_0000};
        @(negedge clk);
        clear_in();
        cmd(1, 1'b1, 1'b0, 32'h8000_0000);
        #1;
        for (int m = 0; m < 2; m++) begin
            n_cmp++;
            if (rvalid[m] !== 4'b0001 || dout[m] !== {96'h0, 32'hAAAA_0000} || gnt[m] !== 4'b0010 || s_read[m] !== 4'b1000) begin
                n_bad++;
                $display("FAIL b2b_1 m%0d got rv=%b dout=%h gnt=%b srd=%b", m, rvalid[m], dout[m], gnt[m], s_read[m]);
            end
        end
        s_dout = {32'hBBBB_3333, 96'h0};
        @(negedge clk);
        clear_in();
        #1;
        for (int m = 0; m < 2; m++) begin
            n_cmp++;
            if (rvalid[m] !== 4'b0010 || dout[m] !== {64'h0, 32'hBBBB_3333, 32'h0}) begin
                n_bad++; $display("FAIL b2b_2 m%0d got rv=%b dout=%h", m, rvalid[m], dout[m]);
            end
        end
    endtask

    task automatic test_reset_drop();
        apply_reset();
        @(negedge clk);
        cmd(0, 1'b0, 1'b1, 32'h0);
        @(negedge clk);
        clear_in();
        cmd(1, 1'b1, 1'b0, 32'h2000_0000);
        s_dout = {4{32'h5A5A_5A5A}};
        #1;
        n_cmp++;
        if (gnt[1] !== 4'b0010) begin
            n_bad++; $display("FAIL drop_pre_gnt got %b exp 0010", gnt[1]);
        end
        #2;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        clear_in();
        #1;
        n_cmp++;
        if (rvalid[0] !== 4'b0 || rvalid[1] !== 4'b0 || dout[1] !== '0) begin
            n_bad++; $display("FAIL drop_rvalid got %b/%b exp 0000", rvalid[0], rvalid[1]);
        end
        @(negedge clk);
        req = 4'hF;
        #1;
        n_cmp++;
        if (gnt[1] !== 4'b0001 || rvalid[1] !== 4'b0) begin
            n_bad++; $display("FAIL drop_rr_restart got gnt=%b rv=%b exp 0001/0000", gnt[1], rvalid[1]);
        end
        @(negedge clk);
        clear_in();
    endtask

    task automatic test_random();
        int          base [4];
        int          ptr [2], lko [2], pown [2], ptgt [2], ng [2], nt [2];
        bit          pv [2], pmiss [2], pdec [2];
        logic [3:0]  nib;
        logic [3:0]  e_gnt, e_rv, e_swr, e_srd;
        logic [127:0] e_saddr, e_sdin, e_dout;
        logic [15:0] e_ssize;
        int          g, tgt;
        base = '{0, 2, 4, 8};
        apply_reset();
        for (int m = 0; m < 2; m++) begin
            ptr[m] = 0; lko[m] = -1; pv[m] = 0; pown[m] = 0; ptgt[m] = 0; pmiss[m] = 0; pdec[m] = 0;
        end
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            req  = 4'($urandom);
            lock = 4'($urandom & $urandom);
            rd   = 4'($urandom);
            wr   = 4'($urandom & $urandom);
            size = 16'($urandom);
            for (int i = 0; i < 4; i++) begin
                case ($urandom_range(0, 5))
                    0: nib = 4'h0;
                    1: nib = 4'h2;
                    2: nib = 4'h4;
                    3: nib = 4'h8;
                    4: nib = 4'hF;
                    default: nib = 4'($urandom);
                endcase
                addr[i*32 +: 32]   = {nib, 28'($urandom)};
                din[i*32 +: 32]    = $urandom;
                s_dout[i*32 +: 32] = $urandom;
            end
            #1;
            for (int m = 0; m < 2; m++) begin
                g = -1;
                if (lko[m] >= 0 && lock[lko[m]]) begin
                    g = lko[m];
                end else begin
                    for (int k = 0; k < 4; k++) begin
                        int j;
                        j = (m == 0) ? k : (ptr[m] + k) % 4;
                        if (g < 0 && req[j]) g = j;
                    end
                end
                e_gnt = (g >= 0) ? 4'(1 << g) : 4'b0;
                tgt = -1;
                if (g >= 0) begin
                    for (int s = 0; s < 4; s++)
                        if (tgt < 0 && base[s] == int'(addr[g*32 + 28 +: 4])) tgt = s;
                end
                e_saddr = '0; e_sdin = '0; e_ssize = '0; e_swr = '0; e_srd = '0;
                if (g >= 0 && tgt >= 0) begin
                    e_saddr[tgt*32 +: 32] = addr[g*32 +: 32];
                    e_sdin[tgt*32 +: 32]  = din[g*32 +: 32];
                    e_ssize[tgt*4 +: 4]   = size[g*4 +: 4];
                    e_swr[tgt]            = wr[g];
                    e_srd[tgt]            = rd[g];
                end
                e_rv = '0; e_dout = '0;
                if (pv[m]) begin
                    e_rv[pown[m]] = 1'b1;
                    if (!pmiss[m]) e_dout[pown[m]*32 +: 32] = s_dout[ptgt[m]*32 +: 32];
                end
                n_cmp++;
                if (gnt[m] !== e_gnt) begin
                    n_bad++; $display("FAIL rnd_gnt m%0d cyc%0d got %b exp %b", m, cyc, gnt[m], e_gnt);
                end
                n_cmp++;
                if ({s_addr[m], s_din[m], s_size[m], s_write[m], s_read[m]} !== {e_saddr, e_sdin, e_ssize, e_swr, e_srd}) begin
                    n_bad++;
                    $display("FAIL rnd_scmd m%0d cyc%0d got a=%h w=%b r=%b exp a=%h w=%b r=%b",
                             m, cyc, s_addr[m], s_write[m], s_read[m], e_saddr, e_swr, e_srd);
                end
                n_cmp++;
                if (rvalid[m] !== e_rv || dout[m] !== e_dout) begin
                    n_bad++;
                    $display("FAIL rnd_ret m%0d cyc%0d got rv=%b d=%h exp rv=%b d=%h", m, cyc, rvalid[m], dout[m], e_rv, e_dout);
                end
                n_cmp++;
                if (dec_err[m] !== pdec[m]) begin
                    n_bad++; $display("FAIL rnd_dec_err m%0d cyc%0d got %b exp %b", m, cyc, dec_err[m], pdec[m]);
                end
                ng[m] = g;
                nt[m] = tgt;
            end
            @(posedge clk);
            for (int m = 0; m < 2; m++) begin
                g   = ng[m];
                tgt = nt[m];
                lko[m]   = (g >= 0 && lock[g]) ? g : -1;
                if (g >= 0 && !lock[g]) ptr[m] = (g + 1) % 4;
                pv[m]    = (g >= 0) && rd[g];
                pown[m]  = (g >= 0) ? g : 0;
                ptgt[m]  = (tgt >= 0) ? tgt : 0;
                pmiss[m] = (tgt < 0);
                pdec[m]  = (g >= 0) && (tgt < 0) && (rd[g] || wr[g]);
            end
        end
        @(negedge clk);
        clear_in();
    endtask

    initial begin
        rst_n = 1'b0;
        clear_in();
        s_dout = '0;
        test_reset();
        test_fixed_read();
        test_rr();
        test_lock();
        test_dec_err();
        test_back_to_back();
        test_reset_drop();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
